// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header: strips byte_remove_cnt head bytes per packet and re-packs the rest MSB-aligned.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove
);
  localparam int CW = BYTE_CNT_WD + 1;
  typedef enum logic [1:0] {IDLE, FIRST, STREAM, TAIL} state_t;
  state_t                  state_q;
  logic [BYTE_CNT_WD-1:0]  r_q;
  logic [DATA_WD-1:0]      res_q, tail_q, data_q;
  logic [CW-1:0]           tail_n_q;
  logic [DATA_BYTE_WD-1:0] keep_q;
  logic                    valid_q, last_q;
  logic [CW-1:0]           cnt, l_n, wr_n, lr_n, c_n;
  logic [DATA_WD-1:0]      din_m, din_sh, join_d;
  logic                    out_free, acc, r_zero, fits;

  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CW-1:0] n);
    keep_of = ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] mask_of(input logic [DATA_BYTE_WD-1:0] k);
    for (int i = 0; i < DATA_BYTE_WD; i++) mask_of[8*i +: 8] = {8{k[i]}};
  endfunction

  assign out_free     = !valid_q || ready_out;
  assign ready_in     = (state_q == FIRST || state_q == STREAM) && out_free;
  assign ready_remove = state_q == IDLE;
  assign acc          = valid_in && ready_in;
  assign valid_out    = valid_q;
  assign data_out     = data_q;
  assign keep_out     = keep_q;
  assign last_out     = last_q;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) cnt = cnt + CW'(keep_in[i]);
    l_n    = last_in ? cnt : CW'(DATA_BYTE_WD);
    r_zero = r_q == '0;
    wr_n   = CW'(DATA_BYTE_WD) - CW'(r_q);
    lr_n   = l_n - CW'(r_q);
    c_n    = wr_n + l_n;
    fits   = l_n <= CW'(r_q);
    din_m  = data_in & mask_of(keep_of(l_n));
    din_sh = din_m << {r_q, 3'b000};
    join_d = res_q | (din_m >> {wr_n, 3'b000});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      res_q    <= '0;
      tail_q   <= '0;
      tail_n_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      if (valid_q && ready_out) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      case (state_q)
        IDLE: if (valid_remove) begin
          r_q     <= byte_remove_cnt;
          state_q <= FIRST;
        end
        FIRST, STREAM: if (acc) begin
          res_q <= din_sh;
          if (r_zero || state_q == STREAM) begin
            valid_q  <= 1'b1;
            data_q   <= r_zero ? din_m : join_d;
            keep_q   <= r_zero ? keep_of(l_n) : (last_in && fits) ? keep_of(c_n) : '1;
            last_q   <= last_in && (r_zero || fits);
            tail_q   <= din_sh;
            tail_n_q <= lr_n;
            state_q  <= !last_in ? STREAM : (!r_zero && !fits) ? TAIL : IDLE;
          end else begin
            // first beat with a header to drop: it only primes the residual unless it is also last
            if (last_in && !fits) begin
              valid_q <= 1'b1;
              data_q  <= din_sh;
              keep_q  <= keep_of(lr_n);
              last_q  <= 1'b1;
            end
            state_q <= last_in ? IDLE : STREAM;
          end
        end
        TAIL: if (out_free) begin
          valid_q <= 1'b1;
          data_q  <= tail_q;
          keep_q  <= keep_of(tail_n_q);
          last_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb_axi_stream_remove_header: scoreboard bench for the header stripper with a byte-level packet model.
module tb_axi_stream_remove_header;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, last_in, ready_in, valid_out, last_out, ready_out, valid_remove, ready_remove;
  logic [31:0] data_in, data_out;
  logic [3:0]  keep_in, keep_out;
  logic [1:0]  byte_remove_cnt;
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  beat_t       exp_q[$];

  axi_stream_remove_header dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt), .ready_remove(ready_remove)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) ready_out = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && valid_out && ready_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got %h/%b/%b required no beat", data_out, keep_out, last_out);
      end else begin
        e = exp_q.pop_front();
        if ({data_out, keep_out, last_out} !== e) begin
          errors++;
          $display("FAIL out_beat got %h/%b/%b required %h/%b/%b", data_out, keep_out, last_out, e.d, e.k, e.l);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back('{d: d, k: k, l: l});
  endtask

  task automatic cmd(input int r);
    int n = 0;
    valid_remove = 1'b1;
    byte_remove_cnt = 2'(r);
    do begin @(negedge clk); n++; end while (!ready_remove && n < 200);
    if (!ready_remove) begin
      checks++; errors++;
      $display("FAIL cmd_timeout ready_remove=%b required 1", ready_remove);
    end
    @(posedge clk);
    #1;
    valid_remove = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    do begin @(negedge clk); n++; end while (!ready_in && n < 200);
    if (!ready_in) begin
      checks++; errors++;
      $display("FAIL send_timeout ready_in=%b required 1", ready_in);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic wait_drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int r, input int nb, input int ll, output time dt);
    logic [7:0]  bytes[$];
    logic [31:0] d[8];
    logic [3:0]  k[8];
    logic [31:0] dd;
    time         t0;
    int          n;
    for (int b = 0; b < nb; b++) begin
      d[b] = $urandom;
      k[b] = (b == nb - 1) ? 4'hF << (4 - ll) : 4'hF;
      for (int j = 0; j < ((b == nb - 1) ? ll : 4); j++) bytes.push_back(d[b][31-8*j -: 8]);
    end
    for (int j = 0; j < r && bytes.size() > 0; j++) void'(bytes.pop_front());
    while (bytes.size() > 0) begin
      n = bytes.size() < 4 ? bytes.size() : 4;
      dd = '0;
      for (int j = 0; j < n; j++) dd[31-8*j -: 8] = bytes.pop_front();
      push(dd, 4'hF << (4 - n), bytes.size() == 0);
    end
    t0 = $time;
    for (int b = 0; b < nb; b++) send(d[b], k[b], b == nb - 1);
    dt = $time - t0;
  endtask

  task automatic test_reset;
    checks++;
    if ({valid_out, data_out, keep_out, last_out} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%h/%b/%b required 0", valid_out, data_out, keep_out, last_out);
    end
    checks++;
    if (ready_remove !== 1'b1 || ready_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got rr=%b ri=%b required rr=1 ri=0", ready_remove, ready_in);
    end
  endtask

  task automatic test_passthrough;
    logic [31:0] d[3] = '{32'hAABBCCDD, 32'h11223344, 32'h55660000};
    logic [3:0]  k[3] = '{4'b1111, 4'b1111, 4'b1100};
    cmd(0);
    for (int i = 0; i < 3; i++) begin
      push(d[i], k[i], i == 2);
      send(d[i], k[i], i == 2);
      checks++;
      if (valid_out !== 1'b1 || data_out !== d[i]) begin
        errors++;
        $display("FAIL passthrough_latency beat %0d got %b/%h required 1/%h", i, valid_out, data_out, d[i]);
      end
    end
    wait_drain();
  endtask

  task automatic test_r1(input bit bp);
    cmd(1);
    push(32'hA1A2A3B0, 4'b1111, 1'b0);
    push(32'hB1B2B3C0, 4'b1111, 1'b0);
    push(32'hC1000000, 4'b1000, 1'b1);
    send(32'h00A1A2A3, 4'b1111, 1'b0);
    send(32'hB0B1B2B3, 4'b1111, 1'b0);
    if (bp) begin
      ready_out = 1'b0;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hA1A2A3B0 || ready_in !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_hold got v=%b d=%h ri=%b required v=1 d=a1a2a3b0 ri=0", valid_out, data_out, ready_in);
        end
      end
      @(posedge clk);
      #1;
      ready_out = 1'b1;
    end
    send(32'hC0C10000, 4'b1100, 1'b1);
    wait_drain();
  endtask

  task automatic test_r2_single_final;
    cmd(2);
    push(32'hAABBCC00, 4'b1110, 1'b1);
    send(32'h0000AABB, 4'b1111, 1'b0);
    send(32'hCC000000, 4'b1000, 1'b1);
    wait_drain();
  endtask

  task automatic test_drop;
    cmd(3);
    send(32'h12345678, 4'b1100, 1'b1);
    checks++;
    if (ready_remove !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL drop got rr=%b v=%b required rr=1 v=0", ready_remove, valid_out);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid;
    cmd(1);
    send(32'h00A1A2A3, 4'b1111, 1'b0);
    send(32'hB0B1B2B3, 4'b1111, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || ready_remove !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got v=%b rr=%b required v=0 rr=1", valid_out, ready_remove);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_r1(1'b0);
  endtask

  task automatic test_throughput;
    time dt;
    cmd(1);
    send_pkt(1, 6, 4, dt);
    checks++;
    if (dt != 60) begin
      errors++;
      $display("FAIL throughput got %0t required 60 for 6 beats", dt);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back;
    time dt;
    rand_ready = 1'b1;
    repeat (30) begin
      cmd($urandom_range(0, 3));
      send_pkt(int'(byte_remove_cnt), $urandom_range(1, 4), $urandom_range(1, 4), dt);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    ready_out = 1'b1;
    wait_drain();
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    ready_out = 1'b1; valid_remove = 1'b0; byte_remove_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_r1(1'b0);
    test_r2_single_final();
    test_drop();
    test_r1(1'b1);
    test_reset_mid();
    test_throughput();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_remove_header.md
Name: axi_stream_remove_header

Overview:
- Per-packet AXI-Stream header stripper: deletes the first byte_remove_cnt bytes of each packet and re-packs the remaining bytes MSB-aligned across beats.
- Sits directly downstream of the header-insert stage and consumes its output stream.
- Byte order is big-endian: the first byte is at data[DATA_WD-1 -: 8], and keep bit [DATA_BYTE_WD-1] marks the first byte.
- The removal count comes from a per-packet sideband handshake, one command per packet.

Parameters:
- DATA_WD, 32, data bus width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (W).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_remove_cnt.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input data.
- keep_in  in  DATA_BYTE_WD  byte enables, contiguous from MSB.
- last_in  in  1  last beat of packet.
- ready_in  out  1  input ready (combinational).
- valid_out  out  1  output beat valid (registered).
- data_out  out  DATA_WD  output data (registered).
- keep_out  out  DATA_BYTE_WD  output byte enables, contiguous from MSB.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.
- valid_remove  in  1  removal command valid.
- byte_remove_cnt  in  BYTE_CNT_WD  bytes to drop from packet head, R = 0..W-1.
- ready_remove  out  1  command ready (combinational).

Behaviour:
- Reset: async on rst high.
  - state=IDLE; valid_out=0, data_out=0, keep_out=0, last_out=0.
  - ready_in=0, ready_remove=1; residual register and R cleared.
  - Reset asserted mid-packet discards all in-flight data; no partial beat is emitted afterwards.
- Input rules: keep_in on non-last beats is treated as all ones. On last beats, L = number of set keep bits, 1..W. Non-contiguous keep is illegal and its behaviour is undefined.
- FSM states: IDLE, FIRST, STREAM, TAIL.
  - IDLE: ready_remove=1, ready_in=0. On valid_remove&&ready_remove, latch R and go to FIRST. A data beat presented in the same cycle is not accepted.
  - FIRST/STREAM: ready_remove=0. ready_in = !valid_out || ready_out.
  - TAIL: ready_in=0, ready_remove=0.
- Output register: a handshake (valid_out&&ready_out) without a new load clears valid_out and last_out. Unused low bytes of data_out are always zero.
- R=0 (pass-through):
  - Each accepted beat loads the output register unchanged next cycle: latency 1.
  - last_in accept: go to IDLE.
- R>0, FIRST:
  - Accepted beat: store its low W-R bytes as residual (RES, W-R bytes). No output; go to STREAM.
  - If that beat has last_in: emit one beat of data_in bytes R..L-1, keep = (L-R) ones, last_out=1, then IDLE.
  - If L<=R, drop the packet: no output, go to IDLE.
- R>0, STREAM, each accepted beat:
  - Output = RES concatenated with the top R bytes of the beat.
  - RES = low W-R bytes of the beat.
- R>0, STREAM, on last_in with L valid bytes, let C = (W-R)+L:
  - C<=W: single final beat = RES concatenated with the top L bytes, keep = C ones, last_out=1; go to IDLE.
  - C>W: load a full beat, keep all ones, last_out=0. Save bytes R..L-1 as tail and go to TAIL.
  - TAIL: when the output register frees (ready_out or !valid_out), load tail, keep = (L-R) ones, last_out=1; go to IDLE.
- Latency for R>0: output beat k is valid the cycle after input beat k+1 is accepted (1-beat bubble at packet start).
- Backpressure: while valid_out && !ready_out, data_out/keep_out/last_out hold stable and ready_in=0. No beat is ever lost or duplicated.
- Back-to-back packets:
  - A new command may be accepted in IDLE while the previous final beat still waits in the output register.
  - The next packet's first beat is accepted only after that register frees.
- Throughput: 1 beat/cycle in steady state with ready_out held high.

Test Plan:
- R=0; beats 0xAABBCCDD, 0x11223344, 0x55660000 (keep 1100, last) -> identical beats out one cycle after each accept, last keep 1100.
- R=1; beats 0x00A1A2A3, 0xB0B1B2B3, 0xC0C10000 (keep 1100, last) -> outputs:
  - 0xA1A2A3B0 keep 1111
  - 0xB1B2B3C0 keep 1111
  - 0xC1000000 keep 1000 last (TAIL path).
- R=2; beats 0x0000AABB, 0xCC000000 (keep 1000, last) -> single output 0xAABBCC00 keep 1110 last, no tail beat.
- R=3; single beat keep 1100 last -> no output beat; ready_remove high again the next cycle.
- Repeat the R=1 case with ready_out low for 3 cycles mid-packet -> data_out stable, ready_in low, identical output sequence.
- Assert rst mid-packet (R=1, after 2nd beat) -> valid_out=0 immediately, ready_remove=1. A fresh packet afterwards is output correctly.
